sram_ctrl: RTL



---
 rtl/sram_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: bridges single-word synchronous requests to a 1M x 16 async SRAM.
// Every SRAM pin is driven straight from a flop. Pin levels are decoded from
// the next state, so each pin changes on the same edge as the state change.
module sram_ctrl #(
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [19:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic [1:0]  i_be,
  output logic        o_busy,
  output logic        o_ack,
  output logic [15:0] o_rdata,
  output logic [19:0] o_sram_addr,
  output logic        o_sram_ce_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n,
  inout  logic [15:0] io_sram_dq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_ACK
  } state_e;

  localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        lb_n_q, lb_n_d;
  logic        ub_n_q, ub_n_d;
  logic        dq_oe_q, dq_oe_d;

  // Next-state, capture and pin decode; pins follow state_d so they leave flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE, S_ACK: begin
        state_d = S_IDLE;
        if (i_req) begin
          addr_d  = i_addr;
          wdata_d = i_wdata;
          be_d    = i_be;
          if (i_we) begin
            state_d = S_WR_SETUP;
            cnt_d   = WR_LOAD;
          end else begin
            state_d = S_RD_WAIT;
            cnt_d   = RD_LOAD;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = {be_q[1] ? io_sram_dq[15:8] : 8'h00,
                     be_q[0] ? io_sram_dq[7:0]  : 8'h00};
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_HOLD: state_d = S_ACK;
      default:   state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE) && (state_d != S_ACK);
    ack_d   = (state_d == S_ACK);
    ce_n_d  = !busy_d;
    oe_n_d  = (state_d != S_RD_WAIT);
    we_n_d  = (state_d != S_WR_PULSE);
    lb_n_d  = busy_d ? !be_d[0] : 1'b1;
    ub_n_d  = busy_d ? !be_d[1] : 1'b1;
    dq_oe_d = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
              (state_d == S_WR_HOLD);
  end

  // State, captured request and registered SRAM pins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      lb_n_q  <= lb_n_d;
      ub_n_q  <= ub_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign io_sram_dq  = dq_oe_q ? wdata_q : 'z;
  assign o_busy      = busy_q;
  assign o_ack       = ack_q;
  assign o_rdata     = rdata_q;
  assign o_sram_addr = addr_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_lb_n = lb_n_q;
  assign o_sram_ub_n = ub_n_q;

endmodule
